// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types, funct3 codes and size helpers for the load/store unit
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic [2:0] size_of(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Unsigned variants exist only for loads; stores accept SB/SH/SW alone.
    function automatic logic is_legal(input logic [2:0] funct3, input logic store);
        case (funct3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return ~store;
            default:          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - word-addressed data memory port (active-low cs/wr)
interface load_store_unit_if #(
    parameter int ADDR_W = 10
) ();
    logic              cs;
    logic              wr;
    logic [3:0]        mask;
    logic [31:0]       data_wr;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data_rd;

    modport master (
        output cs, wr, mask, data_wr, addr,
        input  data_rd
    );

    modport slave (
        input  cs, wr, mask, data_wr, addr,
        output data_rd
    );
endinterface

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - byte-lane mask, write data shift and load extraction
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [2:0]  size,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    input  logic [63:0] rdata_pair,
    output logic [7:0]  mask,
    output logic [63:0] wdata_shifted,
    output logic [31:0] load_data
);
    logic [7:0]  size_mask;
    logic [31:0] wdata_trim;
    logic [63:0] rd_shifted;

    always_comb begin
        size_mask     = (8'd1 << size) - 8'd1;
        mask          = size_mask << offset;
        case (size)
            3'd1:    wdata_trim = wdata & 32'h0000_00ff;
            3'd2:    wdata_trim = wdata & 32'h0000_ffff;
            default: wdata_trim = wdata;
        endcase
        wdata_shifted = {32'd0, wdata_trim} << {offset, 3'b000};
        rd_shifted    = rdata_pair >> {offset, 3'b000};
        case (funct3)
            F3_B:    load_data = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
            F3_BU:   load_data = {24'd0, rd_shifted[7:0]};
            F3_H:    load_data = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
            F3_HU:   load_data = {16'd0, rd_shifted[15:0]};
            default: load_data = rd_shifted[31:0];
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32 load/store master with misaligned access splitting
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_store,
    input  logic [2:0]         req_funct3,
    input  logic [31:0]        req_addr,
    input  logic [DATA_W-1:0]  req_wdata,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [DATA_W-1:0]  resp_rdata,
    output logic               resp_err,
    load_store_unit_if.master  mem
);
    lsu_state_e        state;
    logic              store_q;
    logic [2:0]        f3_q;
    logic [1:0]        off_q;
    logic [ADDR_W-1:0] word_q;
    logic [DATA_W-1:0] wdata_q;
    logic [31:0]       lo_buf;

    logic [2:0]        size;
    logic              crossing;
    logic [63:0]       rd_pair;
    logic [7:0]        mask8;
    logic [63:0]       wdata64;
    logic [31:0]       load_data;
    logic              addr_unused;

    assign addr_unused = &{1'b0, req_addr[31:ADDR_W+2]};

    assign size     = size_of(f3_q);
    assign crossing = ({1'b0, off_q} + size) > 3'd4;

    // The word being read this cycle is folded in directly so the result can
    // be registered on the same edge that leaves the access state.
    assign rd_pair = (state == ACC1) ? {mem.data_rd, lo_buf} : {32'd0, mem.data_rd};

    lsu_lane_align u_align (
        .offset        (off_q),
        .size          (size),
        .funct3        (f3_q),
        .wdata         (wdata_q),
        .rdata_pair    (rd_pair),
        .mask          (mask8),
        .wdata_shifted (wdata64),
        .load_data     (load_data)
    );

    // Decoded from state so an asynchronous reset drops cs before any negedge.
    always_comb begin
        mem.cs      = 1'b1;
        mem.wr      = 1'b1;
        mem.mask    = 4'd0;
        mem.data_wr = 32'd0;
        mem.addr    = '0;
        case (state)
            ACC0: begin
                mem.cs      = 1'b0;
                mem.wr      = ~store_q;
                mem.addr    = word_q;
                mem.mask    = mask8[3:0];
                mem.data_wr = wdata64[31:0];
            end
            ACC1: begin
                mem.cs      = 1'b0;
                mem.wr      = ~store_q;
                mem.addr    = word_q + ADDR_W'(1);
                mem.mask    = mask8[7:4];
                mem.data_wr = wdata64[63:32];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            store_q    <= 1'b0;
            f3_q       <= 3'd0;
            off_q      <= 2'd0;
            word_q     <= '0;
            wdata_q    <= '0;
            lo_buf     <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        store_q   <= req_store;
                        f3_q      <= req_funct3;
                        off_q     <= req_addr[1:0];
                        word_q    <= req_addr[ADDR_W+1:2];
                        wdata_q   <= req_wdata;
                        req_ready <= 1'b0;
                        if (is_legal(req_funct3, req_store)) begin
                            state <= ACC0;
                        end else begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end
                    end
                end
                ACC0: begin
                    if (!store_q) lo_buf <= mem.data_rd;
                    if (crossing) begin
                        state <= ACC1;
                    end else begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= store_q ? '0 : load_data;
                    end
                end
                ACC1: begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= store_q ? '0 : load_data;
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        resp_rdata <= '0;
                        req_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;
    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    load_store_unit_if #(.ADDR_W(10)) mem_bus ();

    load_store_unit #(.ADDR_W(10), .DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem        (mem_bus)
    );

    logic [31:0] mem [0:1023];

    assign mem_bus.data_rd = mem[mem_bus.addr];

    always @(negedge clk) begin
        if (!mem_bus.cs && !mem_bus.wr) begin
            for (int b = 0; b < 4; b++)
                if (mem_bus.mask[b]) mem[mem_bus.addr][8*b +: 8] <= mem_bus.data_wr[8*b +: 8];
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    int          lat;
    int          n_acc;
    logic [31:0] o_addr [0:1];
    logic [31:0] o_mask [0:1];
    logic [31:0] o_data [0:1];
    logic [31:0] o_wr   [0:1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd);
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat   = 99;
        n_acc = 0;
        for (int c = 1; c <= 10; c++) begin
            if (!mem_bus.cs && n_acc < 2) begin
                o_addr[n_acc] = 32'(mem_bus.addr);
                o_mask[n_acc] = 32'(mem_bus.mask);
                o_data[n_acc] = mem_bus.data_wr;
                o_wr[n_acc]   = 32'(mem_bus.wr);
                n_acc++;
            end
            if (resp_valid) begin
                lat = c;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic finish_resp();
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    initial begin
        rst        = 1'b0;
        req_valid  = 1'b0;
        req_store  = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        resp_ready = 1'b0;
        #22;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_cs", 32'(mem_bus.cs), 32'd1);
        chk("rst_wr", 32'(mem_bus.wr), 32'd1);
        chk("rst_mask", 32'(mem_bus.mask), 32'd0);
        chk("rst_data_wr", mem_bus.data_wr, 32'd0);
        chk("rst_addr", 32'(mem_bus.addr), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        run_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        chk("sw_nacc", 32'(n_acc), 32'd1);
        chk("sw_wr", o_wr[0], 32'd0);
        chk("sw_addr", o_addr[0], 32'd4);
        chk("sw_mask", o_mask[0], 32'hF);
        chk("sw_data", o_data[0], 32'hDEADBEEF);
        chk("sw_lat", 32'(lat), 32'd2);
        chk("sw_rdata", resp_rdata, 32'd0);
        chk("sw_req_ready", 32'(req_ready), 32'd0);
        finish_resp();
        chk("sw_mem4", mem[4], 32'hDEADBEEF);

        run_req(1'b0, 3'b010, 32'h10, 32'd0);
        chk("lw_wr", o_wr[0], 32'd1);
        chk("lw_lat", 32'(lat), 32'd2);
        chk("lw_rdata", resp_rdata, 32'hDEADBEEF);
        chk("lw_err", 32'(resp_err), 32'd0);
        finish_resp();

        run_req(1'b1, 3'b000, 32'h13, 32'h000000A5);
        chk("sb_mask", o_mask[0], 32'h8);
        chk("sb_data", o_data[0], 32'hA5000000);
        finish_resp();
        chk("sb_mem4", mem[4], 32'hA5ADBEEF);

        run_req(1'b0, 3'b000, 32'h13, 32'd0);
        chk("lb_rdata", resp_rdata, 32'hFFFFFFA5);
        finish_resp();
        run_req(1'b0, 3'b100, 32'h13, 32'd0);
        chk("lbu_rdata", resp_rdata, 32'h000000A5);
        finish_resp();
        run_req(1'b0, 3'b001, 32'h12, 32'd0);
        chk("lh_rdata", resp_rdata, 32'hFFFFA5AD);
        finish_resp();

        run_req(1'b1, 3'b010, 32'h22, 32'h11223344);
        chk("swx_nacc", 32'(n_acc), 32'd2);
        chk("swx_addr0", o_addr[0], 32'd8);
        chk("swx_mask0", o_mask[0], 32'hC);
        chk("swx_data0", o_data[0], 32'h33440000);
        chk("swx_addr1", o_addr[1], 32'd9);
        chk("swx_mask1", o_mask[1], 32'h3);
        chk("swx_data1", o_data[1], 32'h00001122);
        chk("swx_lat", 32'(lat), 32'd3);
        finish_resp();

        run_req(1'b0, 3'b010, 32'h22, 32'd0);
        chk("lwx_lat", 32'(lat), 32'd3);
        chk("lwx_rdata", resp_rdata, 32'h11223344);
        finish_resp();
        run_req(1'b0, 3'b101, 32'h22, 32'd0);
        chk("lhu_rdata", resp_rdata, 32'h00003344);
        finish_resp();

        run_req(1'b1, 3'b010, 32'hFFC, 32'h9A000000);
        finish_resp();
        run_req(1'b1, 3'b010, 32'h000, 32'h00000085);
        finish_resp();
        run_req(1'b0, 3'b001, 32'hFFF, 32'd0);
        chk("lhw_addr0", o_addr[0], 32'h3FF);
        chk("lhw_mask0", o_mask[0], 32'h8);
        chk("lhw_addr1", o_addr[1], 32'd0);
        chk("lhw_mask1", o_mask[1], 32'h1);
        chk("lhw_lat", 32'(lat), 32'd3);
        chk("lhw_rdata", resp_rdata, 32'hFFFF859A);
        finish_resp();

        run_req(1'b0, 3'b011, 32'h10, 32'd0);
        chk("ill_nacc", 32'(n_acc), 32'd0);
        chk("ill_lat", 32'(lat), 32'd1);
        chk("ill_err", 32'(resp_err), 32'd1);
        chk("ill_rdata", resp_rdata, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("ill_hold_valid", 32'(resp_valid), 32'd1);
            chk("ill_hold_err", 32'(resp_err), 32'd1);
            chk("ill_hold_ready", 32'(req_ready), 32'd0);
            chk("ill_hold_cs", 32'(mem_bus.cs), 32'd1);
        end
        finish_resp();
        chk("ill_done_valid", 32'(resp_valid), 32'd0);
        chk("ill_done_ready", 32'(req_ready), 32'd1);

        run_req(1'b1, 3'b010, 32'h14, 32'h12345678);
        finish_resp();
        req_valid  = 1'b1;
        req_store  = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h14;
        req_wdata  = 32'hCAFEF00D;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("abort_cs_active", 32'(mem_bus.cs), 32'd0);
        rst = 1'b0;
        #1;
        chk("abort_cs", 32'(mem_bus.cs), 32'd1);
        chk("abort_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk); #1;
        chk("abort_mem5", mem[5], 32'h12345678);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_idle_ready", 32'(req_ready), 32'd1);
        chk("abort_idle_valid", 32'(resp_valid), 32'd0);
        run_req(1'b0, 3'b010, 32'h14, 32'd0);
        chk("abort_lw", resp_rdata, 32'h12345678);
        finish_resp();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator-side master for the word-addressed data memory port: cs/wr active-low, 4-bit byte mask, word address, combinational read data, write committed on clk negedge.
- Accepts byte-addressed RV32 load/store requests from the core over a valid/ready handshake.
- Generates byte-lane masks and lane-shifted write data; extracts and sign/zero-extends read data.
- Splits word-crossing misaligned accesses into two sequential memory accesses.

Parameters:
- ADDR_W, 10, memory word-address width; word index = req_addr[ADDR_W+1:2].
- DATA_W, 32, memory word width; fixed at 32, present for package consistency only.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- req_valid  input  1  core request valid
- req_ready  output  1  unit can accept a request (high only in IDLE)
- req_store  input  1  1 = store, 0 = load
- req_funct3  input  3  RV32 funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010)
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned
- resp_valid  output  1  response valid
- resp_ready  input  1  core accepts response
- resp_rdata  output  32  extended load data (0 for stores and errors)
- resp_err  output  1  illegal funct3; no memory access was made
- cs  output  1  memory chip select, active-low
- wr  output  1  0 = write, 1 = read
- mask  output  4  byte-lane enables
- data_wr  output  32  lane-aligned write data
- addr  output  ADDR_W  memory word address
- data_rd  input  32  memory read data (combinational)

Behaviour:
- Reset values (asynchronous on rst low):
  - state = IDLE; req_ready = 1; resp_valid = 0; resp_rdata = 0; resp_err = 0.
  - cs = 1, wr = 1, mask = 0, data_wr = 0, addr = 0.
  - Effect is immediate, so a write in progress is cancelled before the negedge.
- FSM states: IDLE, ACC0, ACC1, RESP.
- IDLE:
  - On req_valid, register the request.
  - Legal funct3 -> ACC0. Illegal funct3 -> RESP with resp_err = 1.
- ACC0:
  - Drive cs = 0; wr = ~req_store; addr = word index; mask = lane mask low half; data_wr = shifted data low half.
  - Loads capture data_rd into lo_buf at posedge.
  - If the access crosses a word boundary -> ACC1, else -> RESP.
- ACC1:
  - Same as ACC0 with addr = word index + 1, wrapping modulo 2^ADDR_W (1023 -> 0), and high halves.
  - Loads capture hi_buf. Next state RESP.
- RESP:
  - resp_valid = 1; outputs held stable until resp_ready.
  - On resp_ready -> IDLE.
- Memory-side outputs are idle values in IDLE and RESP.
- Size and offset:
  - Size s = 1/2/4 bytes from funct3[1:0]; offset o = req_addr[1:0].
  - Crossing when o + s > 4.
  - 8-bit lane mask = ((1<<s)-1) << o; 64-bit write data = zero-extended req_wdata << 8*o.
  - Low halves go to ACC0, high halves to ACC1.
  - Bytes outside s are zeroed and never written.
- Load extraction:
  - 64-bit {hi_buf, lo_buf} >> 8*o, truncated to s bytes.
  - Sign-extend for LB/LH, zero-extend for LBU/LHU; hi_buf = 0 when not crossing.
- Latency from request accept to resp_valid: 2 cycles aligned, 3 cycles crossing, 1 cycle error.
- Throughput: one request in flight; req_ready = 0 outside IDLE.
- req_addr[31:ADDR_W+2] is ignored (aliases).
- A store's memory write commits on the negedge inside its ACCn cycle.

Decomposition:
- Package lsu_pkg:
  - Typedef lsu_state_e {IDLE, ACC0, ACC1, RESP}.
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - Function size_of(funct3).
- Sub-module lsu_lane_align (combinational):
  - Inputs: offset, size, wdata, {hi, lo}, funct3.
  - Outputs: 8-bit mask, 64-bit shifted write data, extended load data.
  - The FSM stays in load_store_unit.

Test Plan:
- SW addr 0x10, data 0xDEADBEEF -> ACC0: cs = 0, wr = 0, addr = 4, mask = 1111; then LW 0x10 -> resp_rdata = 0xDEADBEEF, resp_valid 2 cycles after accept.
- SB addr 0x13, data 0x000000A5; then LB 0x13 -> mask = 1000, data_wr = 0xA5000000; LB returns 0xFFFFFFA5, LBU returns 0x000000A5.
- SW addr 0x22, data 0x11223344 (crossing):
  - ACC0: addr 8, mask 1100, data_wr 0x33440000.
  - ACC1: addr 9, mask 0011, data_wr 0x00001122.
  - Following LW 0x22 returns 0x11223344 with 3-cycle latency.
- LH addr 0xFFF (word 1023, offset 3) -> ACC1 addr wraps to 0; result = {mem[0][7:0], mem[1023][31:24]} sign-extended.
- Illegal funct3 011 load -> no cs assertion, resp_err = 1, resp_rdata = 0; resp_ready held low 3 cycles -> response held stable, req_ready stays 0.
- rst low during ACC0 of a store before the negedge -> cs = 1 immediately, target word unchanged, state IDLE, req_ready = 1 after release.
